hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-003 SHALL have port: forward_stall  input  1  load-use hazard from the forwarding unit (ID/EX consumer of EX/MEM load).
REQ-004 SHALL have port: imem_resp  input  1  icache has returned the instruction for the current PC this cycle.
REQ-005 SHALL have port: dmem_req  input  1  EX/MEM holds a load or store.
REQ-006 SHALL have port: dmem_resp  input  1  dcache completed the EX/MEM access this cycle.
REQ-007 SHALL have port: br_redirect  input  1  EX resolved a taken branch/jal/jalr; PC source already selects the target.
REQ-008 SHALL have ports: load_pc, load_ifid, load_idex, load_exmem, load_memwb  output  1 each  pipeline register load enables.
REQ-009 SHALL have ports: bubble_ifid, bubble_idex, bubble_exmem  output  1 each  load a NOP (load_regfile=0, no memory op) instead of upstream data; meaningful only with the matching load_*.
REQ-010 SHALL have ports: stall_cycles, flush_count  output  32 each  performance counters.
REQ-011 SHALL have port: hz_state  output  2  current state (hazard_state_t) for debug.

Function
REQ-012 SHALL be a Moore/Mealy FSM with states RUN, DMISS, DRAIN; enable/bubble outputs combinational from state and inputs.
REQ-013 Priority, every state: dmem stall > load-use > redirect > icache stall > normal advance.
REQ-014 dmem stall (dmem_req=1, dmem_resp=0): all load_*=0, all bubble_*=0; next state DMISS (from RUN/DMISS) or remain DRAIN.
REQ-015 DMISS: held while dmem stall persists; in the dmem_resp=1 cycle, RUN rules apply and next state is determined by them.
REQ-016 Load-use (forward_stall=1, no dmem stall): load_pc=load_ifid=load_idex=0; load_exmem=1, bubble_exmem=1; load_memwb=1; br_redirect ignored; state RUN.
REQ-017 Redirect with imem_resp=1: all load_*=1, bubble_ifid=1, bubble_idex=1; flush_count+1; state RUN.
REQ-018 Redirect with imem_resp=0 (fetch cannot be cancelled): same enables as REQ-016; next state DRAIN.
REQ-019 DRAIN, no dmem stall, imem_resp=0: REQ-016 enables (branch held in ID/EX, bubbles into EX/MEM).
REQ-020 DRAIN, no dmem stall, imem_resp=1: discard fetched word; all load_*=1, bubble_ifid=1, bubble_idex=1; flush_count+1; next RUN.
REQ-021 DRAIN with br_redirect=0 (protocol violation): behave as RUN this cycle, next RUN.
REQ-022 Icache stall only (RUN, imem_resp=0): load_pc=0, load_ifid=1 with bubble_ifid=1, other load_*=1.
REQ-023 Normal advance: all load_*=1, all bubble_*=0.
REQ-024 stall_cycles SHALL increment in every non-reset cycle with load_pc=0; both counters wrap modulo 2^32.

Reset
REQ-025 While rst=0: state RUN, counters 0, all load_*=1, all bubble_*=1 (pipeline flushes to NOPs).
REQ-026 Reset mid-DMISS or mid-DRAIN SHALL abandon the pending operation; no flush_count update on that cycle.

Structure
REQ-027 hazard_state_t (2-bit enum RUN=0, DMISS=1, DRAIN=2) SHALL live in package ctrl_types.
REQ-028 Both counters SHALL be instances of one sub-module perf_counter (32-bit, sync active-low clear, inc enable).

Verification
REQ-029 dmem_req=1, dmem_resp=0 for 5 cycles then 1 -> all load_*=0 for 5 cycles, hz_state=DMISS, stall_cycles=5, then full advance.
REQ-030 forward_stall=1 one cycle, imem_resp=1 -> load_pc/ifid/idex=0, bubble_exmem=1; next cycle normal; stall_cycles+1.
REQ-031 br_redirect=1, imem_resp=1 -> bubble_ifid=bubble_idex=1, load_pc=1, flush_count 0->1, hz_state stays RUN.
REQ-032 br_redirect=1 with imem_resp=0 for 3 cycles then 1 -> DRAIN 3 cycles, load_idex=0, bubble_exmem=1; 4th cycle flush, flush_count+1, RUN.
REQ-033 In DRAIN, dmem stall 2 cycles -> all loads 0, state stays DRAIN; then REQ-032 completion.
REQ-034 rst=0 asserted during DMISS -> next cycle hz_state=RUN, counters 0, all bubble_*=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package ctrl_types;

  // Controller state, also exported on hz_state for debug.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    DRAIN = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// 32-bit free-running event counter with synchronous active-low clear.
module perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  // Clear wins over increment; the count wraps naturally modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= 32'd0;
    end else if (inc) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns dcache/icache stalls, load-use hazards
// and branch redirects into pipeline register load/bubble controls.
module hazard_ctrl
  import ctrl_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        forward_stall,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        br_redirect,
  output logic        load_pc,
  output logic        load_ifid,
  output logic        load_idex,
  output logic        load_exmem,
  output logic        load_memwb,
  output logic        bubble_ifid,
  output logic        bubble_idex,
  output logic        bubble_exmem,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [1:0]  hz_state
);

  hazard_state_t state_reg;
  hazard_state_t state_next;
  logic          flush_inc;
  logic          stall_inc;
  logic          dmem_stall;

  assign dmem_stall = dmem_req && !dmem_resp;

  // Priority decode: dmem stall > load-use > redirect > icache stall > advance.
  // DMISS and DRAIN only change where a dmem stall leaves us; a DRAIN with
  // the redirect dropped simply falls through to the ordinary rules.
  always_comb begin
    load_pc      = 1'b1;
    load_ifid    = 1'b1;
    load_idex    = 1'b1;
    load_exmem   = 1'b1;
    load_memwb   = 1'b1;
    bubble_ifid  = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    flush_inc    = 1'b0;
    state_next   = RUN;
    if (!rst) begin
      // Flush every stage to NOPs while in reset.
      bubble_ifid  = 1'b1;
      bubble_idex  = 1'b1;
      bubble_exmem = 1'b1;
    end else if (dmem_stall) begin
      load_pc    = 1'b0;
      load_ifid  = 1'b0;
      load_idex  = 1'b0;
      load_exmem = 1'b0;
      load_memwb = 1'b0;
      state_next = (state_reg == DRAIN) ? DRAIN : DMISS;
    end else if (forward_stall) begin
      load_pc      = 1'b0;
      load_ifid    = 1'b0;
      load_idex    = 1'b0;
      bubble_exmem = 1'b1;
    end else if (br_redirect) begin
      if (imem_resp) begin
        // Wrong-path fetch and decode are squashed; PC takes the target.
        bubble_ifid = 1'b1;
        bubble_idex = 1'b1;
        flush_inc   = 1'b1;
      end else begin
        // Outstanding fetch cannot be cancelled: hold the branch in ID/EX
        // until the stale word arrives, then discard it.
        load_pc      = 1'b0;
        load_ifid    = 1'b0;
        load_idex    = 1'b0;
        bubble_exmem = 1'b1;
        state_next   = DRAIN;
      end
    end else if (!imem_resp) begin
      load_pc     = 1'b0;
      bubble_ifid = 1'b1;
    end
  end

  assign stall_inc = rst && !load_pc;

  // State register; reset abandons any pending miss or drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign hz_state = state_reg;

  perf_counter u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  perf_counter u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule
